// File: rtl/slave_out_port.sv
// slave_out_port: one-word holding register feeding an LSB-first serial burst.
// Define SLAVE_OUT_REPEAT_EN to repeat the previous word on underrun (default: zeros).
module slave_out_port #(
  parameter int WORD_SIZE  = 8,
  parameter int BURST_SIZE = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BURST_SIZE-1:0] burst_size,
  input  logic [WORD_SIZE-1:0]  word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  tx_serial,
  output logic                  s_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  underrun
);

  localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    OFFER,
    SEND
  } state_t;

  state_t                state;
  logic [WORD_SIZE-1:0]  hold;
  logic                  hold_full;
  logic [WORD_SIZE-1:0]  shreg;
  logic [WORD_SIZE-1:0]  cur_word;
  logic [BW-1:0]         bit_cnt;
  logic [BURST_SIZE-1:0] word_cnt;
  logic [BURST_SIZE-1:0] burst_latched;

  logic                  wr;
  logic                  hs;
  logic                  boundary;
  logic                  last_word;
  logic                  consume;
  logic [WORD_SIZE-1:0]  fill_word;
  logic [WORD_SIZE-1:0]  load_word;

  assign word_ready = !hold_full;
  assign busy       = (state != IDLE);
  assign wr         = word_valid && word_ready;
  assign hs         = (state == OFFER) && m_ready;
  assign boundary   = (state == SEND) && (bit_cnt == LAST_BIT);
  assign last_word  = (word_cnt == burst_latched - BURST_SIZE'(1));
  assign consume    = hs || (boundary && !last_word && hold_full);

`ifdef SLAVE_OUT_REPEAT_EN
  assign fill_word = cur_word;
`else
  assign fill_word = '0;
`endif

  // In OFFER hold is always full, so this covers both load points.
  assign load_word = hold_full ? hold : fill_word;

  // Holding register: consumption and writes are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (consume) begin
      hold_full <= 1'b0;
    end else if (wr) begin
      hold      <= word_in;
      hold_full <= 1'b1;
    end
  end

  // Burst sequencer with registered serial and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      cur_word      <= '0;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      burst_latched <= '0;
      tx_serial     <= 1'b0;
      s_valid       <= 1'b0;
      tx_done       <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_serial <= 1'b0;
          if (start) begin
            burst_latched <= (burst_size == '0) ?
                             BURST_SIZE'(1) : burst_size;
            word_cnt      <= '0;
            state         <= WAIT_WORD;
          end
        end
        WAIT_WORD: begin
          if (hold_full) begin
            s_valid <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            s_valid   <= 1'b0;
            shreg     <= load_word;
            cur_word  <= load_word;
            tx_serial <= load_word[0];
            bit_cnt   <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (boundary) begin
            if (last_word) begin
              tx_done   <= 1'b1;
              tx_serial <= 1'b0;
              shreg     <= '0;
              bit_cnt   <= '0;
              state     <= IDLE;
            end else begin
              underrun  <= !hold_full;
              word_cnt  <= word_cnt + BURST_SIZE'(1);
              bit_cnt   <= '0;
              shreg     <= load_word;
              cur_word  <= load_word;
              tx_serial <= load_word[0];
            end
          end else begin
            bit_cnt   <= bit_cnt + BW'(1);
            shreg     <= shreg >> 1;
            tx_serial <= shreg[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/slave_out_port.md
# slave_out_port

Serial transmit port on the slave side of the system bus, directly upstream of the master's serial receive port. It accepts parallel words from the slave core through a one-word holding register. After a single valid/ready handshake with the master, it streams a burst of `burst_size` words back-to-back on one serial line, LSB first, with no gaps between words. Word timing lines up exactly with the master receive port's bit and word counting.

## Interface
Parameters:
- `WORD_SIZE`, 8, bits per word.
- `BURST_SIZE`, 15, width of the `burst_size` input.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  core request to begin a burst; sampled only in IDLE.
- `burst_size`  in  BURST_SIZE  number of words in the burst; latched when `start` is accepted.
- `word_in`  in  WORD_SIZE  next word from the core.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  holding register is empty; the core may write.
- `tx_serial`  out  1  serial data to the master's `rx_data`.
- `s_valid`  out  1  slave offers a burst.
- `m_ready`  in  1  master is ready to receive.
- `busy`  out  1  state is not IDLE.
- `tx_done`  out  1  one-cycle pulse when the last bit has been driven out.
- `underrun`  out  1  one-cycle pulse when a word boundary finds the holding register empty.

## Operation
- Holding register `hold` with flag `hold_full`.
  - `word_ready = !hold_full` (combinational).
  - A write occurs when `word_valid && word_ready`.
  - Writes are allowed in every state, including IDLE, so the core can prefetch.
- State machine: IDLE, WAIT_WORD, OFFER, SEND.
  - IDLE: on `start`, latch `burst_size`; a value of 0 is latched as 1. Clear the word counter, then go to WAIT_WORD.
  - WAIT_WORD: go to OFFER once `hold_full` is set.
  - OFFER: `s_valid`=1. At the first edge where `s_valid && m_ready`:
    - load the shift register from `hold` and clear `hold_full`;
    - drive bit 0 of the word onto `tx_serial`, drop `s_valid`;
    - go to SEND.
  - SEND: at each edge, shift out the next bit. After bit WORD_SIZE-1 of word j:
    - if j < N-1: load the next word from `hold` and drive its bit 0 at the same edge, with no idle cycle;
    - if j = N-1: go to IDLE, pulse `tx_done`, set `tx_serial`=0.
- Underrun: at an intermediate word boundary with `hold_full`=0, pulse `underrun` and transmit an all-zero word.
  - The word counter still advances, so the master stays aligned.
  - A word written at that same edge goes into `hold` and is used for the next word slot.
- `m_ready` is ignored outside OFFER, and `start` is ignored outside IDLE.
- Reset, asynchronous, at any time including mid-burst:
  - state = IDLE, `hold_full`=0;
  - `tx_serial`=0, `s_valid`=0, `busy`=0, `tx_done`=0, `underrun`=0;
  - counters and shift register = 0.

## Timing
- Let T be the handshake edge, where `s_valid`=1 and `m_ready`=1 are sampled.
  - Bit k of word j is on `tx_serial` during the cycle following edge T+j·WORD_SIZE+k.
  - The master samples that bit at edge T+j·WORD_SIZE+k+1.
- `tx_done` is high during the cycle after edge T+N·WORD_SIZE.
  - `busy` falls at that same edge.
  - A new `start` is accepted at the following edge.
- Latency from `start` to `s_valid`:
  - 2 cycles if `hold` is already full (IDLE→WAIT_WORD→OFFER);
  - otherwise 1 cycle after `hold_full` rises.
- To avoid underrun, word j+1 must be written by edge T+(j+1)·WORD_SIZE. This gives the core WORD_SIZE cycles per word.
- Word counter width is BURST_SIZE; the comparison is `word_cnt == burst_latched-1`.

## Configuration
- `SLAVE_OUT_REPEAT_EN` defined: on underrun, the previously transmitted word is repeated instead of zeros. The `underrun` pulse is unchanged.
- Not defined: an underrun word is all zeros.

## Test plan
- Single word: write 0xA5, `start`, `burst_size`=1, `m_ready` high → `s_valid` for 1 cycle. `tx_serial` shows 1,0,1,0,0,1,0,1 over 8 cycles, then `tx_done` pulses. The master receive port outputs `s_data`=0xA5.
- Burst of 3: words 0x01, 0x80, 0xFF each supplied within 8 cycles → 24 contiguous bits with no gap and no `underrun`. The master receives 0x01, 0x80, 0xFF, and `rx_done` coincides with the slave `tx_done`.
- Master not ready: `m_ready` low for 5 cycles in OFFER → `s_valid` is held high for 5 cycles and `tx_serial` stays 0. The first bit appears the cycle after `m_ready` rises.
- Underrun: `burst_size`=2, second word withheld → `underrun` pulses at edge T+8.
  - Word 1 is 0x00, or a repeat of word 0 with `SLAVE_OUT_REPEAT_EN`.
  - `tx_done` still pulses at T+16.
- Reset mid-burst: assert `rst_n`=0 during bit 3 of word 0 → all outputs are 0 immediately and `word_ready`=1 after release. A new burst then completes normally.
- `burst_size`=0 → exactly one word is sent and `tx_done` pulses.
